// File: rtl/ps2_key_scheduler.sv
// PS/2 set-2 scan-code parser, held-key tracker and command FIFO for the game keys.
// Define KEY_REPEAT_EN to compile in the auto-repeat engine for held arrow keys.
module ps2_key_scheduler #(
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 2500000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       inclock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] held_keys,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic       key_hit_c, key_arrow_c;
  logic [2:0] key_idx_c;
  logic       make_c, brk_c, make_push_c;
  logic       push_c;
  logic [2:0] push_code_c;
  logic [4:0] held_q, held_d;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q;
  logic          overflow_q;
  logic          full_c, pop_c, wr_c;

  // Scan-code to command-code map
  always_comb begin
    key_hit_c   = 1'b0;
    key_arrow_c = 1'b0;
    key_idx_c   = 3'd0;
    case (ps2_key_data)
      8'h75: begin key_hit_c = 1'b1; key_arrow_c = 1'b1; key_idx_c = 3'd0; end
      8'h72: begin key_hit_c = 1'b1; key_arrow_c = 1'b1; key_idx_c = 3'd1; end
      8'h6B: begin key_hit_c = 1'b1; key_arrow_c = 1'b1; key_idx_c = 3'd2; end
      8'h74: begin key_hit_c = 1'b1; key_arrow_c = 1'b1; key_idx_c = 3'd3; end
      8'h29: begin key_hit_c = 1'b1; key_idx_c = 3'd4; end
      default: ;
    endcase
  end

  always_ff @(posedge inclock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Parser next state; SPACE is only recognised without the E0 prefix
  always_comb begin
    state_d = state_q;
    make_c  = 1'b0;
    brk_c   = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == 8'hE0)      state_d = ST_EXT;
          else if (ps2_key_data == 8'hF0) state_d = ST_BRK;
          else                            make_c  = key_hit_c;
        end
        ST_EXT: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            make_c  = key_arrow_c;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          brk_c   = key_hit_c;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          brk_c   = key_arrow_c;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign make_push_c = make_c & ~held_q[key_idx_c];

  always_comb begin
    held_d = held_q;
    if (make_push_c) held_d[key_idx_c] = 1'b1;
    if (brk_c)       held_d[key_idx_c] = 1'b0;
  end

  always_ff @(posedge inclock) begin
    if (reset) held_q <= '0;
    else       held_q <= held_d;
  end

`ifdef KEY_REPEAT_EN
  logic        act_vld_q, act_vld_d;
  logic [2:0]  act_key_q, act_key_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        first_q, first_d;
  logic        rep_due_c, rep_push_c;

  // Repeat engine: a make push always wins over a repeat due the same cycle
  always_comb begin
    act_vld_d  = act_vld_q;
    act_key_d  = act_key_q;
    rcnt_d     = rcnt_q;
    first_d    = first_q;
    rep_push_c = 1'b0;
    rep_due_c  = act_vld_q &&
                 (rcnt_q == (first_q ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1)));
    if (make_push_c && key_arrow_c) begin
      act_vld_d = 1'b1;
      act_key_d = key_idx_c;
      rcnt_d    = '0;
      first_d   = 1'b1;
    end else if (brk_c && act_vld_q && (key_idx_c == act_key_q)) begin
      act_vld_d = 1'b0;
      rcnt_d    = '0;
    end else if (act_vld_q) begin
      if (rep_due_c) begin
        rcnt_d     = '0;
        first_d    = 1'b0;
        rep_push_c = ~make_push_c;
      end else begin
        rcnt_d = rcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge inclock) begin
    if (reset) begin
      act_vld_q <= 1'b0;
      act_key_q <= '0;
      rcnt_q    <= '0;
      first_q   <= 1'b1;
    end else begin
      act_vld_q <= act_vld_d;
      act_key_q <= act_key_d;
      rcnt_q    <= rcnt_d;
      first_q   <= first_d;
    end
  end

  assign push_c      = make_push_c | rep_push_c;
  assign push_code_c = make_push_c ? key_idx_c : act_key_q;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};

  assign push_c      = make_push_c;
  assign push_code_c = key_idx_c;
`endif

  // Command FIFO; full is judged on the registered count so a same-cycle pop cannot admit a push
  assign full_c = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop_c  = (fcnt_q != '0) & cmd_ready;
  assign wr_c   = push_c & ~full_c;

  always_ff @(posedge inclock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      fcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wp_q] <= push_code_c;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop_c) rp_q <= rp_q + AW'(1);
      case ({wr_c, pop_c})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (push_c && full_c) overflow_q <= 1'b1;
    end
  end

  assign cmd_valid = (fcnt_q != '0);
  assign cmd_code  = mem_q[rp_q];
  assign held_keys = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed self-checking bench for ps2_key_scheduler; expectations follow KEY_REPEAT_EN.
module tb_ps2_key_scheduler;

  logic       inclock = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] held_keys;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mk0, mk1;

  ps2_key_scheduler #(
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8),
    .FIFO_DEPTH   (4)
  ) dut (
    .inclock        (inclock),
    .reset          (reset),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .held_keys      (held_keys),
    .overflow       (overflow)
  );

  always #5 inclock = ~inclock;
  always @(posedge inclock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change at the falling edge and are sampled by the DUT on the next rising edge
  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge inclock);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic expect_push(input string tag, input logic [2:0] code);
    check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check_eq({tag, "_code"}, 32'(cmd_code), 32'(code));
    @(negedge inclock);
  endtask

  task automatic quiet_until(input string tag, input int t);
    while (cyc < t) begin
      check_eq(tag, 32'(cmd_valid), 32'd0);
      @(negedge inclock);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check_eq({tag, "_code"}, 32'(cmd_code), 32'd0);
    check_eq({tag, "_held"}, 32'(held_keys), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge inclock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge inclock);
    reset = 1'b0;
    check_reset_outputs("por");

    // Extended LEFT held then released, sink always ready
    cmd_ready = 1'b1;
    send(8'hE0);
    mk0 = cyc;
    send(8'h6B);
    check_eq("left_held", 32'(held_keys), 32'h04);
    expect_push("left_make", 3'd2);
`ifdef KEY_REPEAT_EN
    quiet_until("left_gap1", mk0 + 21);
    check_eq("left_held_mid", 32'(held_keys), 32'h04);
    expect_push("left_rep1", 3'd2);
    quiet_until("left_gap2", mk0 + 29);
    expect_push("left_rep2", 3'd2);
`endif
    quiet_until("left_gap3", mk0 + 30);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check_eq("left_released", 32'(held_keys), 32'h00);
    quiet_until("left_after_brk", cyc + 20);

    // SPACE: single push, never repeats; E0 29 ignored
    mk0 = cyc;
    send(8'h29);
    check_eq("space_held", 32'(held_keys), 32'h10);
    expect_push("space_make", 3'd4);
    quiet_until("space_norep", mk0 + 30);
    send(8'hE0);
    send(8'h29);
    check_eq("e0_29_held", 32'(held_keys), 32'h10);
    quiet_until("e0_29_nopush", cyc + 3);
    send(8'hF0);
    send(8'h29);
    check_eq("space_released", 32'(held_keys), 32'h00);

    // Five distinct makes into a stalled FIFO of four
    pulse_reset();
    cmd_ready = 1'b0;
    send(8'h75);
    send(8'h72);
    send(8'hE0);
    send(8'h6B);
    send(8'h74);
    send(8'h29);
    check_eq("full_valid", 32'(cmd_valid), 32'd1);
    check_eq("full_ovf", 32'(overflow), 32'd1);
    check_eq("full_held", 32'(held_keys), 32'h1F);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 32'(cmd_valid), 32'd1);
      check_eq("drain_code", 32'(cmd_code), 32'(i));
      cmd_ready = 1'b1;
      @(negedge inclock);
      cmd_ready = 1'b0;
    end
    check_eq("drained_empty", 32'(cmd_valid), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // RIGHT make lands on UP's repeat-due cycle
    pulse_reset();
    cmd_ready = 1'b1;
    mk0 = cyc;
    send(8'h75);
    expect_push("up_make", 3'd0);
    quiet_until("up_wait", mk0 + 20);
    mk1 = cyc;
    send(8'h74);
    expect_push("right_make", 3'd3);
    quiet_until("right_only", mk1 + 21);
`ifdef KEY_REPEAT_EN
    expect_push("right_rep1", 3'd3);
`endif
    mk1 = mk1 + 21;
    while (cyc < mk1) @(negedge inclock);
    send(8'hF0);
    send(8'h75);
    check_eq("up_released", 32'(held_keys), 32'h08);
`ifdef KEY_REPEAT_EN
    quiet_until("right_gap", mk1 + 8);
    expect_push("right_rep2", 3'd3);
`else
    quiet_until("right_gap", mk1 + 9);
`endif

    // Unknown bytes and typematic repeats
    pulse_reset();
    cmd_ready = 1'b1;
    send(8'h1C);
    check_eq("unk_nopush", 32'(cmd_valid), 32'd0);
    send(8'hF0);
    send(8'h1C);
    check_eq("unk_brk_nopush", 32'(cmd_valid), 32'd0);
    send(8'h75);
    expect_push("up_once", 3'd0);
    send(8'h75);
    send(8'h75);
    quiet_until("typematic", cyc + 2);
    check_eq("up_still_held", 32'(held_keys), 32'h01);
    send(8'hE0);
    send(8'h1C);
    send(8'h72);
    expect_push("down_after_unk", 3'd1);
    check_eq("up_down_held", 32'(held_keys), 32'h03);

    // Reset mid-sequence with a non-empty FIFO; strobe during reset ignored
    pulse_reset();
    cmd_ready = 1'b0;
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    check_eq("pre_rst_valid", 32'(cmd_valid), 32'd1);
    reset           = 1'b1;
    ps2_key_data    = 8'h74;
    ps2_key_pressed = 1'b1;
    @(negedge inclock);
    reset           = 1'b0;
    ps2_key_pressed = 1'b0;
    check_reset_outputs("mid_rst");
    send(8'h72);
    check_eq("post_rst_held", 32'(held_keys), 32'h02);
    check_eq("post_rst_valid", 32'(cmd_valid), 32'd1);
    check_eq("post_rst_code", 32'(cmd_code), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
